// File: rtl/decode_ctrl_stage.sv
// Registered instruction decode stage with valid/ready flow control and a mult/div busy window.
// Optional MD_HAZARD_EN: while busy, stall only mult/div and readers of the pending mult/div rd.
module decode_ctrl_stage #(
  parameter int DATA_W    = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              jump,
  output logic              j2,
  output logic              bne,
  output logic              blt,
  output logic              bex,
  output logic              weDM,
  output logic              weReg,
  output logic              weRegDM,
  output logic              ALUop,
  output logic              immediate,
  output logic              weStatus,
  output logic              weReturn,
  output logic              mult_or_div,
  output logic              illegal,
  output logic [4:0]        rd,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] imm_ext,
  output logic [DATA_W-1:0] target_ext,
  output logic              md_busy
);

  typedef enum logic [4:0] {
    OP_ALU  = 5'd0,
    OP_J    = 5'd1,
    OP_BNE  = 5'd2,
    OP_JAL  = 5'd3,
    OP_JR   = 5'd4,
    OP_ADDI = 5'd5,
    OP_BLT  = 5'd6,
    OP_SW   = 5'd7,
    OP_LW   = 5'd8,
    OP_SETX = 5'd9,
    OP_BEX  = 5'd10
  } opcode_e;

  localparam logic [4:0] SUB_MULT = 5'd6;
  localparam logic [4:0] SUB_DIV  = 5'd7;
  localparam logic [7:0] MD_LOAD  = 8'(MD_CYCLES);

  typedef struct packed {
    logic jump;
    logic j2;
    logic bne;
    logic blt;
    logic bex;
    logic weDM;
    logic weReg;
    logic weRegDM;
    logic ALUop;
    logic immediate;
    logic weStatus;
    logic weReturn;
    logic mult_or_div;
    logic illegal;
  } ctrl_t;

  logic [4:0]        op;
  ctrl_t             ctrl_d, ctrl_q;
  logic [4:0]        rd_q, rs_q, rt_q, alu_op_q;
  logic [DATA_W-1:0] imm_d, imm_q, tgt_d, tgt_q;
  logic              out_valid_q;
  logic [7:0]        md_cnt_q;
  logic              stall, accept, out_hs;

  assign op    = instr[31:27];
  assign imm_d = {{(DATA_W-17){instr[16]}}, instr[16:0]};
  assign tgt_d = {{(DATA_W-27){1'b0}}, instr[26:0]};

  always_comb begin
    ctrl_d = '0;
    case (op)
      OP_ALU: begin
        ctrl_d.ALUop       = 1'b1;
        ctrl_d.weReg       = 1'b1;
        ctrl_d.weStatus    = 1'b1;
        ctrl_d.mult_or_div = (instr[6:2] == SUB_MULT) || (instr[6:2] == SUB_DIV);
      end
      OP_J:    ctrl_d.jump = 1'b1;
      OP_BNE:  begin ctrl_d.bne = 1'b1; ctrl_d.immediate = 1'b1; end
      OP_JAL:  begin ctrl_d.jump = 1'b1; ctrl_d.weReg = 1'b1; ctrl_d.weReturn = 1'b1; end
      OP_JR:   begin ctrl_d.jump = 1'b1; ctrl_d.j2 = 1'b1; end
      OP_ADDI: begin ctrl_d.weReg = 1'b1; ctrl_d.immediate = 1'b1; ctrl_d.weStatus = 1'b1; end
      OP_BLT:  begin ctrl_d.blt = 1'b1; ctrl_d.immediate = 1'b1; end
      OP_SW:   begin ctrl_d.weDM = 1'b1; ctrl_d.immediate = 1'b1; end
      OP_LW:   begin ctrl_d.weReg = 1'b1; ctrl_d.weRegDM = 1'b1; ctrl_d.immediate = 1'b1; end
      OP_SETX: begin ctrl_d.weReg = 1'b1; ctrl_d.weStatus = 1'b1; end
      OP_BEX:  ctrl_d.bex = 1'b1;
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

  assign md_busy = (md_cnt_q != '0);

`ifdef MD_HAZARD_EN
  logic [4:0] md_rd_q;
  logic       src_hit;

  // Register 0 is hardwired, so a pending write to it never creates a dependency.
  always_comb begin
    src_hit = 1'b0;
    case (op)
      OP_ALU:                src_hit = (instr[21:17] == md_rd_q) || (instr[16:12] == md_rd_q);
      OP_ADDI, OP_LW:        src_hit = (instr[21:17] == md_rd_q);
      OP_SW, OP_BNE, OP_BLT: src_hit = (instr[26:22] == md_rd_q) || (instr[21:17] == md_rd_q);
      OP_JR:                 src_hit = (instr[26:22] == md_rd_q);
      OP_BEX:                src_hit = (md_rd_q == 5'd30);
      default:               src_hit = 1'b0;
    endcase
  end

  assign stall = md_busy & (ctrl_d.mult_or_div | (src_hit & (md_rd_q != '0)));
`else
  assign stall = md_busy;
`endif

  assign in_ready = ~reset & ~flush & (~out_valid_q | out_ready) & ~stall;
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      alu_op_q    <= '0;
      imm_q       <= '0;
      tgt_q       <= '0;
      md_cnt_q    <= '0;
`ifdef MD_HAZARD_EN
      md_rd_q     <= '0;
`endif
    end else begin
      if (flush)       out_valid_q <= 1'b0;
      else if (accept) out_valid_q <= 1'b1;
      else if (out_hs) out_valid_q <= 1'b0;

      if (accept) begin
        ctrl_q   <= ctrl_d;
        rd_q     <= instr[26:22];
        rs_q     <= instr[21:17];
        rt_q     <= instr[16:12];
        alu_op_q <= instr[6:2];
        imm_q    <= imm_d;
        tgt_q    <= tgt_d;
      end

      // The busy window starts when execute takes the mult/div, not when decode accepts it.
      if (out_hs && ctrl_q.mult_or_div) begin
        md_cnt_q <= MD_LOAD;
`ifdef MD_HAZARD_EN
        md_rd_q  <= rd_q;
`endif
      end else if (md_cnt_q != '0) begin
        md_cnt_q <= md_cnt_q - 8'd1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign {jump, j2, bne, blt, bex, weDM, weReg, weRegDM, ALUop, immediate,
          weStatus, weReturn, mult_or_div, illegal} = ctrl_q;
  assign rd         = rd_q;
  assign rs         = rs_q;
  assign rt         = rt_q;
  assign alu_op     = alu_op_q;
  assign imm_ext    = imm_q;
  assign target_ext = tgt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: reference decode model, expected-entry queue, busy-window model.
module tb_decode_ctrl_stage;

  localparam int MD_C = 4;

  typedef struct packed {
    logic [13:0] ctrl;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [31:0] tgt;
  } ent_t;

  logic        clock, reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr;
  logic        jump, j2, bne, blt, bex, weDM, weReg, weRegDM, ALUop, immediate;
  logic        weStatus, weReturn, mult_or_div, illegal, md_busy;
  logic [4:0]  rd, rs, rt, alu_op;
  logic [31:0] imm_ext, target_ext;
  ent_t        obs;

  decode_ctrl_stage #(.DATA_W(32), .MD_CYCLES(MD_C)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .jump(jump), .j2(j2), .bne(bne), .blt(blt), .bex(bex), .weDM(weDM),
    .weReg(weReg), .weRegDM(weRegDM), .ALUop(ALUop), .immediate(immediate),
    .weStatus(weStatus), .weReturn(weReturn), .mult_or_div(mult_or_div),
    .illegal(illegal), .rd(rd), .rs(rs), .rt(rt), .alu_op(alu_op),
    .imm_ext(imm_ext), .target_ext(target_ext), .md_busy(md_busy)
  );

  assign obs = {jump, j2, bne, blt, bex, weDM, weReg, weRegDM, ALUop, immediate,
                weStatus, weReturn, mult_or_div, illegal, rd, rs, rt, alu_op,
                imm_ext, target_ext};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int   vectors = 0;
  int   miscompares = 0;
  ent_t sb[$];
  ent_t cur;
  logic exp_ov;
  int   exp_cnt;
  logic last_rdy;
`ifdef MD_HAZARD_EN
  logic [4:0] exp_mdrd;
`endif

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int d, input int s, input int t, input int sub);
    return {5'(op), 5'(d), 5'(s), 5'(t), 5'd0, 5'(sub), 2'b00};
  endfunction

  // ctrl bit order: jump j2 bne blt bex weDM weReg weRegDM ALUop immediate weStatus weReturn md illegal
  function automatic ent_t mdl(input logic [31:0] w);
    ent_t e;
    logic [13:0] c;
    case (w[31:27])
      5'd0:    c = {8'b0000_0010, 1'b1, 1'b0, 1'b1, 1'b0, (w[6:2] == 5'd6 || w[6:2] == 5'd7), 1'b0};
      5'd1:    c = 14'b10000000000000;
      5'd2:    c = 14'b00100000010000;
      5'd3:    c = 14'b10000010000100;
      5'd4:    c = 14'b11000000000000;
      5'd5:    c = 14'b00000010011000;
      5'd6:    c = 14'b00010000010000;
      5'd7:    c = 14'b00000100010000;
      5'd8:    c = 14'b00000011010000;
      5'd9:    c = 14'b00000010001000;
      5'd10:   c = 14'b00001000000000;
      default: c = 14'b00000000000001;
    endcase
    e.ctrl = c;
    e.rd   = w[26:22];
    e.rs   = w[21:17];
    e.rt   = w[16:12];
    e.alu  = w[6:2];
    e.imm  = {{15{w[16]}}, w[16:0]};
    e.tgt  = {5'b00000, w[26:0]};
    return e;
  endfunction

`ifdef MD_HAZARD_EN
  function automatic bit hz(input logic [31:0] w, input logic [4:0] m);
    logic [4:0] d = w[26:22];
    logic [4:0] s = w[21:17];
    logic [4:0] t = w[16:12];
    bit h;
    case (w[31:27])
      5'd0:             h = (s == m) || (t == m);
      5'd5, 5'd8:       h = (s == m);
      5'd2, 5'd6, 5'd7: h = (d == m) || (s == m);
      5'd4:             h = (d == m);
      5'd10:            h = (m == 5'd30);
      default:          h = 1'b0;
    endcase
    return h && (m != 5'd0);
  endfunction
`endif

  task automatic model_reset();
    exp_ov  = 1'b0;
    cur     = '0;
    exp_cnt = 0;
    sb.delete();
`ifdef MD_HAZARD_EN
    exp_mdrd = '0;
`endif
  endtask

  // Inputs are set at posedge+1; this checks in_ready, crosses one edge and checks the registered state.
  task automatic step();
    logic exp_rdy, stall_m, acc, hs;
    #1;
`ifdef MD_HAZARD_EN
    stall_m = (exp_cnt != 0) && (mdl(instr).ctrl[1] || hz(instr, exp_mdrd));
`else
    stall_m = (exp_cnt != 0);
`endif
    exp_rdy = !flush && (!exp_ov || out_ready) && !stall_m;
    last_rdy = in_ready;
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    acc = in_valid && exp_rdy;
    if (acc) sb.push_back(mdl(instr));
    hs = exp_ov && out_ready;
    if (hs && cur.ctrl[1]) chk("md_reload_while_busy", 128'(md_busy), 128'(0));
    @(posedge clock);
    #1;
    if (hs && cur.ctrl[1]) begin
      exp_cnt = MD_C;
`ifdef MD_HAZARD_EN
      exp_mdrd = cur.rd;
`endif
    end else if (exp_cnt > 0) begin
      exp_cnt--;
    end
    if (flush)    exp_ov = 1'b0;
    else if (acc) exp_ov = 1'b1;
    else if (hs)  exp_ov = 1'b0;
    if (acc) cur = sb.pop_front();
    chk("out_valid", 128'(out_valid), 128'(exp_ov));
    chk("entry", 128'(obs), 128'(cur));
    chk("md_busy", 128'(md_busy), 128'(exp_cnt != 0));
  endtask

  task automatic send(input logic [31:0] w, output int n);
    in_valid = 1'b1;
    instr    = w;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (last_rdy) break;
      n++;
    end
    in_valid = 1'b0;
    chk("send_bound", 128'(last_rdy), 128'(1));
  endtask

  initial begin
    int n;
    logic [31:0] mult_w, dep_w, indep_w;
    mult_w  = enc(0, 4, 1, 2, 6);
    dep_w   = enc(0, 5, 4, 1, 0);
    indep_w = enc(0, 5, 6, 7, 0);
    reset = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    @(posedge clock); #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_entry", 128'(obs), 128'(0));
    chk("rst_md_busy", 128'(md_busy), 128'(0));
    reset = 1'b0;

    // addi r3,r1,-5
    out_ready = 1'b1;
    send(32'h28C3FFFB, n);
    chk("addi_imm", 128'(imm_ext), 128'(32'hFFFFFFFB));
    chk("addi_rd", 128'(rd), 128'(3));
    chk("addi_ctl", 128'({weReg, immediate, weStatus}), 128'(3'b111));

    // jal 0x100 back-to-back with execute stalled for three cycles
    send(32'h18000100, n);
    in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (3) step();
    chk("jal_weReturn", 128'(weReturn), 128'(1));
    chk("jal_target", 128'(target_ext), 128'(32'h100));
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();

    // dependent add after a mult
    send(mult_w, n);
    step();
    send(dep_w, n);
    chk("stall_len_dep", 128'(n), 128'(4));
    step();

    // independent add after a mult
    send(mult_w, n);
    step();
    send(indep_w, n);
`ifdef MD_HAZARD_EN
    chk("stall_len_indep", 128'(n), 128'(0));
`else
    chk("stall_len_indep", 128'(n), 128'(4));
`endif
    repeat (5) step();

    // mult right behind a mult
    send(mult_w, n);
    step();
    send(enc(0, 8, 9, 10, 7), n);
    chk("stall_len_md", 128'(n), 128'(4));
    step();

    // illegal opcode 31, then flush while held
    send(32'hF8123456, n);
    out_ready = 1'b0;
    chk("ill_flag", 128'(illegal), 128'(1));
    chk("ill_ctl", 128'({weReg, weDM, weStatus}), 128'(0));
    chk("ill_valid", 128'(out_valid), 128'(1));
    in_valid = 1'b1;
    instr = 32'h28C3FFFB;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();

    // asynchronous reset during a busy window
    send(mult_w, n);
    step();
    in_valid = 1'b1;
    instr = 32'h18000100;
    step();
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_md_busy", 128'(md_busy), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(0));
    model_reset();
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered, flow-controlled successor to the combinational opcode decoder: it accepts one 32-bit instruction per handshake, decodes the full control-bit set plus register fields and extended immediates, and presents them from a pipeline register to the execute stage. It also tracks an in-flight multi-cycle mult/div and stalls dependent instructions. It sits between fetch and execute in the 5-stage core.

## Interface
- `DATA_W`, 32: width of `imm_ext`/`target_ext`.
- `MD_CYCLES`, 32: mult/div busy window in cycles, 1..255.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `instr` valid.
- `in_ready` out 1: stage accepts `instr` this cycle.
- `instr` in 32: instruction word.
- `flush` in 1: squash the registered entry.
- `out_valid` out 1: decoded entry valid.
- `out_ready` in 1: execute consumes the entry.
- `jump`, `j2`, `bne`, `blt`, `bex`, `weDM`, `weReg`, `weRegDM`, `ALUop`, `immediate`, `weStatus`, `weReturn`, `mult_or_div` out 1 each: registered control bits.
- `illegal` out 1: opcode 11..31.
- `rd`, `rs`, `rt` out 5 each: instr[26:22], [21:17], [16:12].
- `alu_op` out 5: instr[6:2].
- `imm_ext` out DATA_W: sign-extended instr[16:0].
- `target_ext` out DATA_W: zero-extended instr[26:0].
- `md_busy` out 1: mult/div window active.

## Operation
- Opcode = instr[31:27]:
  - 0 alu, 1 j, 2 bne, 3 jal, 4 jr, 5 addi, 6 blt, 7 sw, 8 lw, 9 setx, 10 bex.
  - ALU subcodes: mult = 6, div = 7.
- Control equations:
  - jump = j|jal|jr; j2 = jr; weDM = sw; weRegDM = lw; weReturn = jal; ALUop = alu.
  - weReg = alu|jal|addi|lw|setx.
  - immediate = bne|lw|sw|blt|addi.
  - weStatus = alu|setx|addi.
  - mult_or_div = alu & (subcode 6|7).
- Illegal opcode: `illegal` = 1, every other control bit 0; the entry still flows normally.
- Pipeline register: `in_ready = (!out_valid | out_ready) & !stall`. Accept = in_valid & in_ready; on accept all outputs load decoded values and `out_valid` is set.
- On out_valid & out_ready without a new accept, `out_valid` clears. Payload holds its last value.
- `flush`:
  - Clears `out_valid` the next edge and blocks acceptance that cycle (`in_ready` = 0).
  - Has priority over accept.
  - Does not affect the mult/div counter.
- Mult/div counter (8-bit):
  - Loads MD_CYCLES on out handshake of an entry with `mult_or_div` = 1; records that entry's `rd` as `md_rd`.
  - Otherwise decrements when nonzero.
  - `md_busy` = counter != 0.
- Stall, evaluated combinationally on `instr` while `md_busy`:
  - Any incoming mult/div stalls.
  - Other instructions stall per Configuration.
  - `md_rd` = 0 never causes a hazard.
- Source registers per opcode:
  - alu: rs, rt.
  - addi/lw: rs.
  - sw/bne/blt: rd, rs.
  - jr: rd.
  - bex: r30.
  - others: none.

## Timing
- Reset value of every output is 0, including `in_ready`. `in_ready` follows its equation from the first cycle after reset deasserts. Counter = 0, `md_rd` = 0.
- Latency: instruction accepted at edge N is visible on outputs after edge N (1 cycle).
- Throughput: 1 per cycle while `out_ready` = 1 and there is no stall.
- `md_busy` is high for exactly MD_CYCLES cycles following the handshake edge.
- Mult/div handshake while the counter is nonzero: reload to MD_CYCLES and overwrite `md_rd`. This is unreachable by design; the bench asserts it never happens.
- Reset mid-operation clears the entry and the counter immediately (asynchronous).

## Configuration
- `MD_HAZARD_EN` defined: while `md_busy`, stall only mult/div and instructions whose source register equals `md_rd` (nonzero).
- Undefined: while `md_busy`, stall every instruction (`in_ready` = 0). No `md_rd` compare logic is built.

## Test plan
- After reset, `addi r3,r1,-5` (0x28C3FFFB) → one cycle later out_valid = 1, weReg = 1, immediate = 1, weStatus = 1, imm_ext = 0xFFFFFFFB, rd = 3.
- Back-to-back `jal 0x100` with out_ready = 0 for 3 cycles → in_ready = 0, outputs stable, weReturn = 1; one beat transfers when out_ready = 1.
- mult r4,r1,r2 consumed at edge T, MD_CYCLES = 4, then `add r5,r4,r1` → stalled for cycles T+1..T+4, accepted at the following edge.
- Same as above with `MD_HAZARD_EN` and `add r5,r6,r7` → accepted with no stall; a second mult stalls for 4 cycles.
- Opcode 31 → illegal = 1, weReg = weDM = weStatus = 0, out_valid = 1.
- `flush` asserted with out_valid = 1 and in_valid = 1 → out_valid = 0 next cycle, the instruction is not accepted, and md_busy is unchanged.
